// File: rtl/notch_coeff_ctrl_pkg.sv
// notch_ctrl_pkg: shared constants and types for the notch coefficient
// controller (register offsets, reset coefficient sets, FSM state encoding,
// coefficient slot indices).
package notch_ctrl_pkg;

  // Number of coefficients per stage: {b0,b1,b2,a1,a2}
  localparam int N_COEFF = 5;

  // Coefficient slot indices; b0 occupies the MSBs of the packed vector
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

  // Register byte offsets
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_SETTLE   = 8'h08;
  localparam logic [7:0] OFF_S1_BASE  = 8'h10;
  localparam logic [7:0] OFF_S2_BASE  = 8'h30;
  localparam logic [7:0] OFF_RB1_BASE = 8'h50;
  localparam logic [7:0] OFF_RB2_BASE = 8'h70;

  // CTRL bit positions
  localparam int CTRL_COMMIT_BIT = 8;

  // Power-up coefficient sets (16-bit S16.14 words, {b0,b1,b2,a1,a2})
  localparam logic [79:0] STAGE1_RST_COEFF = {16'h4000, 16'h678E, 16'h4000, 16'h6502, 16'h3CE4};
  localparam logic [79:0] STAGE2_RST_COEFF = {16'h4000, 16'h4000, 16'h4000, 16'h3E6D, 16'h3CE4};

  // Commit sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } notch_state_e;

endpackage

// File: rtl/notch_coeff_ctrl_if.sv
// notch_coeff_ctrl_if: APB slave bus bundle for the notch coefficient
// controller. master drives the request, slave returns the response.
interface notch_coeff_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/notch_coeff_ctrl_bank.sv
// notch_coeff_bank: five shadow and five active coefficient registers for
// one notch stage. Shadows take single-word writes; load copies all shadows
// into the active set on one edge so the stage never sees a partial set.
module notch_coeff_bank
  import notch_ctrl_pkg::*;
#(
  parameter int                 WIDTH     = 16,
  parameter logic [5*WIDTH-1:0] RST_COEFF = '0
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [2:0]         wr_idx_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               load_i,
  output logic [5*WIDTH-1:0] active_o,
  output logic [5*WIDTH-1:0] shadow_o
);

  for (genvar gi = 0; gi < N_COEFF; gi++) begin : g_coeff
    localparam int LSB = (N_COEFF - 1 - gi) * WIDTH;

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;

    // Shadow word: updated by an accepted software write to this slot
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= RST_COEFF[LSB +: WIDTH];
      end else if (wr_en_i && (wr_idx_i == 3'(gi))) begin
        shadow_q <= wr_data_i;
      end
    end

    // Active word: takes the shadow value on the commit swap edge
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
        active_q <= RST_COEFF[LSB +: WIDTH];
      end else if (load_i) begin
        active_q <= shadow_q;
      end
    end

    assign active_o[LSB +: WIDTH] = active_q;
    assign shadow_o[LSB +: WIDTH] = shadow_q;
  end

endmodule

// File: rtl/notch_coeff_ctrl.sv
// notch_coeff_ctrl: APB-programmable coefficient/mode controller for the
// two-stage notch cascade. Holds CTRL/STATUS/SETTLE, the commit FSM and the
// settle counter; per-stage coefficients live in notch_coeff_bank.
// Optional build macro: NOTCH_ACTIVE_READBACK_EN adds read-only windows on
// the active coefficients at 0x50-0x60 (stage 1) and 0x70-0x80 (stage 2).
module notch_coeff_ctrl
  import notch_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int SETTLE_RST = 8
) (
  input  logic               CLK,
  input  logic               rst_n,
  notch_coeff_ctrl_if.slave  apb,
  input  logic               sample_valid,
  output logic [5*WIDTH-1:0] stage1_coeff,
  output logic [5*WIDTH-1:0] stage2_coeff,
  output logic [1:0]         stage_en,
  output logic [1:0]         stage_bypass,
  output logic               commit_done
);

  notch_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         commit_done_q;
  logic [1:0]   en_q;
  logic [1:0]   bypass_q;
  logic [7:0]   settle_q;
  logic         done_q;

  logic         acc, wr_acc, busy;
  logic         commit_req, sh_wr_ok, load, done_evt;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic         hit_ctrl, hit_status, hit_settle, hit_s1, hit_s2, mapped;
  logic [2:0]   idx;
  logic         err;
  logic [31:0]  rdata;
  logic [5*WIDTH-1:0] s1_shadow, s2_shadow;
  logic [WIDTH-1:0]   s1_sh [N_COEFF];
  logic [WIDTH-1:0]   s2_sh [N_COEFF];
`ifdef NOTCH_ACTIVE_READBACK_EN
  logic               hit_rb1, hit_rb2;
  logic [WIDTH-1:0]   s1_act [N_COEFF];
  logic [WIDTH-1:0]   s2_act [N_COEFF];
`endif

  // Per-slot views of the packed coefficient vectors for the read mux
  for (genvar gi = 0; gi < N_COEFF; gi++) begin : g_view
    assign s1_sh[gi] = s1_shadow[(N_COEFF-1-gi)*WIDTH +: WIDTH];
    assign s2_sh[gi] = s2_shadow[(N_COEFF-1-gi)*WIDTH +: WIDTH];
`ifdef NOTCH_ACTIVE_READBACK_EN
    assign s1_act[gi] = stage1_coeff[(N_COEFF-1-gi)*WIDTH +: WIDTH];
    assign s2_act[gi] = stage2_coeff[(N_COEFF-1-gi)*WIDTH +: WIDTH];
`endif
  end

  assign acc        = apb.PSEL & apb.PENABLE;
  assign wr_acc     = acc & apb.PWRITE;
  assign busy       = (state_q != IDLE);
  // Shadow writes and COMMIT are refused while a commit is in flight
  assign commit_req = wr_acc & hit_ctrl & apb.PWDATA[CTRL_COMMIT_BIT] & ~busy;
  assign sh_wr_ok   = wr_acc & ~busy;

  // Address decode: word-aligned compare, low two address bits ignored
  always_comb begin
    addr_w     = {apb.PADDR[ADDR_WIDTH-1:2], 2'b00};
    hit_ctrl   = (addr_w == ADDR_WIDTH'(OFF_CTRL));
    hit_status = (addr_w == ADDR_WIDTH'(OFF_STATUS));
    hit_settle = (addr_w == ADDR_WIDTH'(OFF_SETTLE));
    hit_s1     = 1'b0;
    hit_s2     = 1'b0;
    idx        = '0;
`ifdef NOTCH_ACTIVE_READBACK_EN
    hit_rb1    = 1'b0;
    hit_rb2    = 1'b0;
`endif
    for (int i = 0; i < N_COEFF; i++) begin
      if (addr_w == ADDR_WIDTH'(OFF_S1_BASE) + ADDR_WIDTH'(4*i)) begin
        hit_s1 = 1'b1;
        idx    = 3'(i);
      end
      if (addr_w == ADDR_WIDTH'(OFF_S2_BASE) + ADDR_WIDTH'(4*i)) begin
        hit_s2 = 1'b1;
        idx    = 3'(i);
      end
`ifdef NOTCH_ACTIVE_READBACK_EN
      if (addr_w == ADDR_WIDTH'(OFF_RB1_BASE) + ADDR_WIDTH'(4*i)) begin
        hit_rb1 = 1'b1;
        idx     = 3'(i);
      end
      if (addr_w == ADDR_WIDTH'(OFF_RB2_BASE) + ADDR_WIDTH'(4*i)) begin
        hit_rb2 = 1'b1;
        idx     = 3'(i);
      end
`endif
    end
`ifdef NOTCH_ACTIVE_READBACK_EN
    mapped = hit_ctrl | hit_status | hit_settle | hit_s1 | hit_s2 | hit_rb1 | hit_rb2;
`else
    mapped = hit_ctrl | hit_status | hit_settle | hit_s1 | hit_s2;
`endif
  end

  // Error response: unmapped, refused while busy, or write to read-only window
  always_comb begin
    err = ~mapped;
    if (apb.PWRITE) begin
      if ((hit_s1 | hit_s2) && busy) err = 1'b1;
      if (hit_ctrl && apb.PWDATA[CTRL_COMMIT_BIT] && busy) err = 1'b1;
`ifdef NOTCH_ACTIVE_READBACK_EN
      if (hit_rb1 | hit_rb2) err = 1'b1;
`endif
    end
  end

  // Read data mux; COMMIT always reads back as 0
  always_comb begin
    rdata = '0;
    if (hit_ctrl) begin
      rdata[3:0] = {bypass_q, en_q};
    end else if (hit_status) begin
      rdata[1:0] = {done_q, busy};
    end else if (hit_settle) begin
      rdata[7:0] = settle_q;
    end else if (hit_s1) begin
      rdata[WIDTH-1:0] = s1_sh[idx];
    end else if (hit_s2) begin
      rdata[WIDTH-1:0] = s2_sh[idx];
`ifdef NOTCH_ACTIVE_READBACK_EN
    end else if (hit_rb1) begin
      rdata[WIDTH-1:0] = s1_act[idx];
    end else if (hit_rb2) begin
      rdata[WIDTH-1:0] = s2_act[idx];
`endif
    end
  end

  assign apb.PRDATA  = acc ? rdata : 32'h0;
  assign apb.PSLVERR = acc & err;
  assign apb.PREADY  = 1'b1;

  // CTRL, SETTLE and sticky done; a done set beats a same-edge clear
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 2'b11;
      bypass_q <= 2'b00;
      settle_q <= 8'(SETTLE_RST);
      done_q   <= 1'b0;
    end else begin
      if (wr_acc && hit_ctrl) begin
        en_q     <= apb.PWDATA[1:0];
        bypass_q <= apb.PWDATA[3:2];
      end
      if (wr_acc && hit_settle) begin
        settle_q <= apb.PWDATA[7:0];
      end
      if (done_evt) begin
        done_q <= 1'b1;
      end else if (wr_acc && hit_status && apb.PWDATA[1]) begin
        done_q <= 1'b0;
      end
    end
  end

  // Commit FSM state, settle counter and the registered completion pulse
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      commit_done_q <= done_evt;
    end
  end

  // Commit FSM next state: wait for a strobe, swap, then mask the transient
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    done_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commit_req) state_d = PENDING;
      end
      PENDING: begin
        if (sample_valid) begin
          load = 1'b1;
          if (settle_q != 8'd0) begin
            state_d = SETTLE;
            cnt_d   = settle_q;
          end else begin
            state_d  = IDLE;
            done_evt = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (sample_valid) begin
          if (cnt_q == 8'd1) begin
            state_d  = IDLE;
            done_evt = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  notch_coeff_bank #(
    .WIDTH     (WIDTH),
    .RST_COEFF (STAGE1_RST_COEFF)
  ) u_bank1 (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .wr_en_i   (sh_wr_ok & hit_s1),
    .wr_idx_i  (idx),
    .wr_data_i (apb.PWDATA[WIDTH-1:0]),
    .load_i    (load),
    .active_o  (stage1_coeff),
    .shadow_o  (s1_shadow)
  );

  notch_coeff_bank #(
    .WIDTH     (WIDTH),
    .RST_COEFF (STAGE2_RST_COEFF)
  ) u_bank2 (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .wr_en_i   (sh_wr_ok & hit_s2),
    .wr_idx_i  (idx),
    .wr_data_i (apb.PWDATA[WIDTH-1:0]),
    .load_i    (load),
    .active_o  (stage2_coeff),
    .shadow_o  (s2_shadow)
  );

  assign stage_en     = en_q;
  assign stage_bypass = bypass_q | {2{state_q == SETTLE}};
  assign commit_done  = commit_done_q;

  // Address LSBs and upper write-data bits carry no information
  logic unused_apb;
  assign unused_apb = ^{apb.PADDR[1:0], apb.PWDATA[31:WIDTH]};

endmodule

// File: tb/tb_notch_coeff_ctrl.sv
// tb_notch_coeff_ctrl: table-driven register checks plus hand-written commit
// sequences; APB responses go through an expected-value queue.
module tb_notch_coeff_ctrl;

  localparam logic [79:0] S1_RST = 80'h4000_678E_4000_6502_3CE4;
  localparam logic [79:0] S2_RST = 80'h4000_4000_4000_3E6D_3CE4;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [79:0] stage1_coeff, stage2_coeff;
  logic [1:0]  stage_en, stage_bypass;
  logic        commit_done;

  notch_coeff_ctrl_if #(.ADDR_WIDTH(8)) apb_bus();

  notch_coeff_ctrl #(
    .WIDTH(16), .ADDR_WIDTH(8), .SETTLE_RST(8)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .apb          (apb_bus),
    .sample_valid (sample_valid),
    .stage1_coeff (stage1_coeff),
    .stage2_coeff (stage2_coeff),
    .stage_en     (stage_en),
    .stage_bypass (stage_bypass),
    .commit_done  (commit_done)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always @(negedge CLK) if (commit_done === 1'b1) done_cnt++;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    logic        is_rd;
  } resp_t;
  resp_t sb_q[$];

  typedef struct {
    string       name;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] with_coef(input logic [79:0] v, input int idx, input logic [15:0] c);
    logic [79:0] r;
    r = v;
    r[(4-idx)*16 +: 16] = c;
    return r;
  endfunction

  function automatic void add_vec(input string n, input logic wr, input logic [7:0] a,
                                  input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = a; v.wdata = wd; v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  // One APB transfer; sv drives sample_valid during the access-phase cycle
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic sv, output logic [31:0] rdata, output logic err);
    @(posedge CLK); #1;
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = wr;
    apb_bus.PADDR = addr; apb_bus.PWDATA = wdata;
    @(posedge CLK); #1;
    apb_bus.PENABLE = 1'b1; sample_valid = sv;
    @(negedge CLK);
    rdata = apb_bus.PRDATA; err = apb_bus.PSLVERR;
    @(posedge CLK); #1;
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic apb_check(input string name, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input logic exp_err, input logic sv);
    resp_t e;
    logic [31:0] rd;
    logic er;
    e.name = name; e.data = exp_data; e.err = exp_err; e.is_rd = ~wr;
    sb_q.push_back(e);
    apb_xfer(wr, addr, wdata, sv, rd, er);
    e = sb_q.pop_front();
    if (e.is_rd) check({e.name, " rdata"}, 80'(rd), 80'(e.data));
    check({e.name, " pslverr"}, 80'(er), 80'(e.err));
    $display("apb %s %s addr=%02h wdata=%08h rdata=%08h err=%0b", e.name, wr ? "WR" : "RD",
             addr, wdata, rd, er);
  endtask

  task automatic rd(input string n, input logic [7:0] a, input logic [31:0] ed, input logic ee);
    apb_check(n, 1'b0, a, 32'h0, ed, ee, 1'b0);
  endtask

  task automatic wr(input string n, input logic [7:0] a, input logic [31:0] wd, input logic ee);
    apb_check(n, 1'b1, a, wd, 32'h0, ee, 1'b0);
  endtask

  task automatic strobe();
    @(posedge CLK); #1 sample_valid = 1'b1;
    @(posedge CLK); #1 sample_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] exp1, exp2;
    int d0;

    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = '0; apb_bus.PWDATA = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst stage1_coeff", stage1_coeff, S1_RST);
    check("rst stage2_coeff", stage2_coeff, S2_RST);
    check("rst stage_en", 80'(stage_en), 80'(2'b11));
    check("rst stage_bypass", 80'(stage_bypass), 80'(2'b00));
    check("rst commit_done", 80'(commit_done), 80'(1'b0));
    check("rst PRDATA", 80'(apb_bus.PRDATA), 80'(32'h0));
    check("rst PSLVERR", 80'(apb_bus.PSLVERR), 80'(1'b0));
    check("rst PREADY", 80'(apb_bus.PREADY), 80'(1'b1));
    @(posedge CLK); #1 rst_n = 1'b1;

    // Register map after reset
    add_vec("rst s1 b0",  1'b0, 8'h10, 32'h0, 32'h4000, 1'b0);
    add_vec("rst s1 b1",  1'b0, 8'h14, 32'h0, 32'h678E, 1'b0);
    add_vec("rst s1 b2",  1'b0, 8'h18, 32'h0, 32'h4000, 1'b0);
    add_vec("rst s1 a1",  1'b0, 8'h1C, 32'h0, 32'h6502, 1'b0);
    add_vec("rst s1 a2",  1'b0, 8'h20, 32'h0, 32'h3CE4, 1'b0);
    add_vec("rst s2 b0",  1'b0, 8'h30, 32'h0, 32'h4000, 1'b0);
    add_vec("rst s2 a1",  1'b0, 8'h3C, 32'h0, 32'h3E6D, 1'b0);
    add_vec("rst s2 a2",  1'b0, 8'h40, 32'h0, 32'h3CE4, 1'b0);
    add_vec("rst ctrl",   1'b0, 8'h00, 32'h0, 32'h3,    1'b0);
    add_vec("rst status", 1'b0, 8'h04, 32'h0, 32'h0,    1'b0);
    add_vec("rst settle", 1'b0, 8'h08, 32'h0, 32'h8,    1'b0);
    add_vec("ctrl lsb ign", 1'b0, 8'h02, 32'h0, 32'h3,  1'b0);
    add_vec("unmap rd 0c", 1'b0, 8'h0C, 32'h0, 32'h0,   1'b1);
    add_vec("unmap rd 24", 1'b0, 8'h24, 32'h0, 32'h0,   1'b1);
    add_vec("unmap rd 44", 1'b0, 8'h44, 32'h0, 32'h0,   1'b1);
    add_vec("unmap wr 0c", 1'b1, 8'h0C, 32'h55, 32'h0,  1'b1);
    add_vec("unmap wr 90", 1'b1, 8'h90, 32'h55, 32'h0,  1'b1);
    add_vec("rb wr 50",    1'b1, 8'h50, 32'h1111, 32'h0, 1'b1);
`ifdef NOTCH_ACTIVE_READBACK_EN
    add_vec("rb rd 54",    1'b0, 8'h54, 32'h0, 32'h678E, 1'b0);
    add_vec("rb rd 7c",    1'b0, 8'h7C, 32'h0, 32'h3E6D, 1'b0);
    add_vec("rb rd 50",    1'b0, 8'h50, 32'h0, 32'h4000, 1'b0);
`else
    add_vec("rb rd 54",    1'b0, 8'h54, 32'h0, 32'h0, 1'b1);
    add_vec("rb rd 7c",    1'b0, 8'h7C, 32'h0, 32'h0, 1'b1);
    add_vec("rb rd 50",    1'b0, 8'h50, 32'h0, 32'h0, 1'b1);
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      apb_check(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_data, vecs[i].exp_err, 1'b0);
    end

    // Commit with SETTLE=3
    d0 = done_cnt;
    wr("s1 b1 wr", 8'h14, 32'h1234, 1'b0);
    wr("settle=3", 8'h08, 32'h3, 1'b0);
    rd("s1 b1 shadow", 8'h14, 32'h1234, 1'b0);
    check("s1 active before commit", stage1_coeff, S1_RST);
    wr("commit A", 8'h00, 32'h103, 1'b0);
    idle(4);
    check("s1 active no strobe", stage1_coeff, S1_RST);
    rd("status busy A", 8'h04, 32'h1, 1'b0);
    exp1 = with_coef(S1_RST, 1, 16'h1234);
    strobe();
    check("A swap s1", stage1_coeff, exp1);
    check("A swap s2", stage2_coeff, S2_RST);
    check("A bypass 1", 80'(stage_bypass), 80'(2'b11));
    check("A done 1", 80'(commit_done), 80'(1'b0));
    strobe();
    check("A bypass 2", 80'(stage_bypass), 80'(2'b11));
    check("A done 2", 80'(commit_done), 80'(1'b0));
    strobe();
    check("A bypass 3", 80'(stage_bypass), 80'(2'b11));
    check("A done 3", 80'(commit_done), 80'(1'b0));
    strobe();
    check("A bypass end", 80'(stage_bypass), 80'(2'b00));
    check("A done pulse", 80'(commit_done), 80'(1'b1));
    rd("status done A", 8'h04, 32'h2, 1'b0);
    check("A done count", 80'(done_cnt - d0), 80'(1));
`ifdef NOTCH_ACTIVE_READBACK_EN
    rd("rb active b1", 8'h54, 32'h1234, 1'b0);
`else
    rd("rb active b1", 8'h54, 32'h0, 1'b1);
`endif
    wr("status w1c", 8'h04, 32'h2, 1'b0);
    rd("status cleared", 8'h04, 32'h0, 1'b0);

    // Commit with SETTLE=0: swap and pulse on the first strobe, no forced bypass
    wr("settle=0", 8'h08, 32'h0, 1'b0);
    wr("s1 b2 wr", 8'h18, 32'h0ABC, 1'b0);
    wr("s2 a1 wr", 8'h3C, 32'h1111, 1'b0);
    wr("commit B", 8'h00, 32'h103, 1'b0);
    check("B bypass pending", 80'(stage_bypass), 80'(2'b00));
    strobe();
    exp1 = with_coef(exp1, 2, 16'h0ABC);
    exp2 = with_coef(S2_RST, 3, 16'h1111);
    check("B swap s1", stage1_coeff, exp1);
    check("B swap s2", stage2_coeff, exp2);
    check("B done pulse", 80'(commit_done), 80'(1'b1));
    check("B bypass", 80'(stage_bypass), 80'(2'b00));
    rd("status B", 8'h04, 32'h2, 1'b0);

    // Refused accesses while busy; CTRL en still accepted
    wr("settle=2", 8'h08, 32'h2, 1'b0);
    wr("commit C", 8'h00, 32'h103, 1'b0);
    wr("busy s2 wr", 8'h30, 32'hDEAD, 1'b1);
    wr("busy commit", 8'h00, 32'h101, 1'b1);
    check("busy stage_en", 80'(stage_en), 80'(2'b01));
    rd("busy s2 shadow", 8'h30, 32'h4000, 1'b0);
    rd("busy status", 8'h04, 32'h3, 1'b0);
    d0 = done_cnt;
    strobe();
    check("C swap s2", stage2_coeff, exp2);
    check("C bypass 1", 80'(stage_bypass), 80'(2'b11));
    strobe();
    strobe();
    check("C done pulse", 80'(commit_done), 80'(1'b1));
    check("C bypass end", 80'(stage_bypass), 80'(2'b00));
    strobe();
    strobe();
    check("C single done", 80'(done_cnt - d0), 80'(1));
    rd("C status idle", 8'h04, 32'h2, 1'b0);
    wr("ctrl en=3", 8'h00, 32'h3, 1'b0);

    // COMMIT on the same edge as a strobe does not use that strobe
    wr("status w1c D", 8'h04, 32'h2, 1'b0);
    wr("s1 a2 wr", 8'h20, 32'h7777, 1'b0);
    wr("settle=1", 8'h08, 32'h1, 1'b0);
    apb_check("commit D +sv", 1'b1, 8'h00, 32'h103, 32'h0, 1'b0, 1'b1);
    @(negedge CLK);
    check("D no swap", stage1_coeff, exp1);
    check("D bypass pending", 80'(stage_bypass), 80'(2'b00));
    strobe();
    exp1 = with_coef(exp1, 4, 16'h7777);
    check("D swap s1", stage1_coeff, exp1);
    check("D bypass", 80'(stage_bypass), 80'(2'b11));
    check("D no done yet", 80'(commit_done), 80'(1'b0));
    strobe();
    check("D done pulse", 80'(commit_done), 80'(1'b1));

    // Reset during SETTLE aborts without a completion pulse
    wr("s2 b1 wr", 8'h34, 32'h5555, 1'b0);
    wr("settle=5", 8'h08, 32'h5, 1'b0);
    wr("commit E", 8'h00, 32'h10F, 1'b0);
    strobe();
    check("E swap s2", stage2_coeff, with_coef(exp2, 1, 16'h5555));
    strobe();
    d0 = done_cnt;
    @(posedge CLK); #1 rst_n = 1'b0;
    @(negedge CLK);
    check("E rst s1", stage1_coeff, S1_RST);
    check("E rst s2", stage2_coeff, S2_RST);
    check("E rst en", 80'(stage_en), 80'(2'b11));
    check("E rst bypass", 80'(stage_bypass), 80'(2'b00));
    check("E rst done", 80'(commit_done), 80'(1'b0));
    idle(2);
    @(posedge CLK); #1 rst_n = 1'b1;
    strobe();
    strobe();
    strobe();
    idle(2);
    check("E no done pulse", 80'(done_cnt - d0), 80'(0));
    rd("E status", 8'h04, 32'h0, 1'b0);
    rd("E settle", 8'h08, 32'h8, 1'b0);
    rd("E s2 b1", 8'h34, 32'h4000, 1'b0);
    rd("E ctrl", 8'h00, 32'h3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/notch_coeff_ctrl.md
# notch_coeff_ctrl

APB-programmable coefficient and mode controller for the two-stage IIR notch cascade (stage 1 and stage 2 Notch_Filter instances). Software writes coefficient sets into shadow registers; a commit swaps both stages' active coefficients atomically on a sample boundary, then forces bypass for a programmable number of samples to mask the filter transient. The block sits between the APB fabric and the `filter_coeff`/`EN`/`bypass` inputs of both notch stages.

## Interface
- `WIDTH`, 16, coefficient width (S16.14).
- `ADDR_WIDTH`, 8, APB byte-address width.
- `SETTLE_RST`, 8, reset value of the settle count, in samples.

- `CLK` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB control.
- `PADDR` in ADDR_WIDTH: byte address; bits [1:0] ignored.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied 1, no wait states.
- `PSLVERR` out 1: error response, valid in the access phase.
- `sample_valid` in 1: strobe marking the cycle in which the notch stages register a new sample.
- `stage1_coeff`, `stage2_coeff` out 5*WIDTH: active `{b0,b1,b2,a1,a2}`, with b0 in the MSBs.
- `stage_en` out 2: per-stage EN; bit 0 is stage 1.
- `stage_bypass` out 2: per-stage bypass.
- `commit_done` out 1: one-cycle pulse when the commit sequence completes.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL: [1:0] en, [3:2] bypass, [8] COMMIT (write-1, reads 0).
  - 0x04 STATUS: [0] busy (RO), [1] done sticky (write-1-to-clear).
  - 0x08 SETTLE: [7:0] settle sample count.
  - 0x10–0x20: stage-1 shadow b0, b1, b2, a1, a2, data in [15:0].
  - 0x30–0x40: stage-2 shadow, same layout.
- APB writes take effect on the access-phase edge (`PSEL & PENABLE & PWRITE`).
- Unmapped addresses: reads return 0 with PSLVERR=1; writes are ignored with PSLVERR=1.
- FSM states: IDLE, PENDING, SETTLE.
  - IDLE: a COMMIT write moves the FSM to PENDING.
  - PENDING: on the first `sample_valid` after entry, active <= shadow for both stages on that edge. The FSM then goes to SETTLE if SETTLE≠0; otherwise it goes to IDLE and pulses `commit_done`.
  - SETTLE: loads the counter with SETTLE on entry and decrements on each `sample_valid`. When `sample_valid` arrives with the counter at 1, the FSM goes to IDLE and pulses `commit_done`.
- `busy` = state≠IDLE.
- `stage_bypass` = CTRL.bypass | {2{state==SETTLE}}.
- `stage_en` = CTRL.en.
- Shadow writes or COMMIT while busy are ignored with PSLVERR=1. CTRL en/bypass bits and SETTLE writes are always accepted.
- `done` sticky is set on the same edge as `commit_done`. If a set and a write-1-to-clear occur on the same edge, the set wins.

## Timing
- Reset values (all outputs and registers):
  - `stage1_coeff` = {4000,678E,4000,6502,3CE4} hex.
  - `stage2_coeff` = {4000,4000,4000,3E6D,3CE4} hex.
  - Shadows equal the active values; en=2'b11; bypass=2'b00; SETTLE=SETTLE_RST; state IDLE.
  - `commit_done`=0, `PRDATA`=0, `PSLVERR`=0.
- `PREADY`=1 always. `PRDATA`/`PSLVERR` are combinational from PADDR during the access phase and 0 otherwise.
- A COMMIT written in the same cycle as `sample_valid` does not use that strobe; the swap happens on the next `sample_valid`.
- Commit-to-active latency is 1 edge after the COMMIT write at minimum, and otherwise unbounded (it waits for a strobe).
- Both stages' coefficients change on the same edge. No partial update is ever visible.
- `rst_n` asserted mid-sequence aborts it. All state returns to reset values and no `commit_done` pulse is issued.

## Configuration
- `NOTCH_ACTIVE_READBACK_EN` defined: offsets 0x50–0x60 (stage 1) and 0x70–0x80 (stage 2) read the active coefficients (read-only). Writes to these offsets are ignored with PSLVERR=1.
- `NOTCH_ACTIVE_READBACK_EN` undefined: these offsets are unmapped (read 0, PSLVERR=1).

## Structure
- Package `notch_ctrl_pkg` holds:
  - register offset constants;
  - reset coefficient constants for both stages;
  - the FSM state enum;
  - the coefficient index constants (B0..A2).
- Sub-module `notch_coeff_bank`, instantiated once per stage, holds five shadow and five active registers. It has a write port (index, data), a `load` input (shadow→active) and packed outputs for active and shadow values.
- The top level contains the APB decode, CTRL/STATUS/SETTLE registers, the FSM and the settle counter.

## Test plan
- Reset: read 0x10 → 0x4000, 0x14 → 0x678E, 0x40 → 0x3CE4. Read 0x00 → 0x3. Read 0x08 → 8.
- Write 0x14=0x1234, then COMMIT with SETTLE=3. `stage1_coeff` is unchanged until the first `sample_valid`, where b1 becomes 0x1234. `stage_bypass`=2'b11 for exactly 3 strobes, then `commit_done` pulses once and STATUS reads 0x2.
- Write SETTLE=0, then COMMIT → coefficients swap on the next strobe. `commit_done` pulses on that edge and `stage_bypass` never forces.
- While busy, write 0x30 and COMMIT → PSLVERR=1 on both and the shadow is unchanged. A CTRL write of en=2'b01 is accepted and `stage_en` becomes 2'b01 on the next edge.
- COMMIT in the same cycle as `sample_valid` → no swap on that edge; the swap happens on the following strobe. Assert `rst_n` during SETTLE → all outputs return to reset values with no `commit_done` pulse.
- Read 0x54:
  - with `NOTCH_ACTIVE_READBACK_EN` defined → active b1, PSLVERR=0;
  - without the macro → 0, PSLVERR=1.
